// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial front end. Accepts a WIDTH-bit word over a
//             valid/ready handshake, shifts it out one bit per clock and
//             inserts GAP idle cycles after each word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       word length in bits (>= 2)
//    MSB_FIRST   1: data_in_i[WIDTH-1] goes out first, 0: data_in_i[0] first
//    GAP         idle cycles after each word (>= 0)
//    IDLE_LEVEL  level driven on bit_out_o when no data bit is sent
//  Ports
//    clk_i         clock, rising edge
//    reset_i       synchronous active-high reset
//    load_valid_i  data_in_i holds a word to send
//    data_in_i     word to serialize, sampled only on an accepted handshake
//    load_ready_o  a word can be accepted this cycle
//    bit_out_o     serial data
//    bit_valid_o   bit_out_o carries a data bit this cycle
//    word_done_o   pulse coinciding with the last bit of a word
//    busy_o        serializer is not idle
// ============================================================================
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP        = 2,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic             load_ready_o,
    output logic             bit_out_o,
    output logic             bit_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    // One counter serves both the bit count and the gap count.
    localparam int C_CNT_MAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_CNT_WORD = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_GAP  = (GAP > 0) ? C_CNT_W'(GAP - 1) : '0;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sreg_q,  sreg_d;

    logic               w_last;
    logic               w_accept;
    logic               w_head;
    logic [WIDTH-1:0]   w_shifted;

    // The output end of the shift register depends on bit order; the
    // register always moves toward that end so the next bit is in place.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head    = sreg_q[WIDTH-1];
            assign w_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = sreg_q[0];
            assign w_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (cnt_q == '0);

    // All outputs decode registered state only.
    // With no gap the last shift cycle can already take the next word,
    // which keeps bit_valid_o high across back-to-back words.
    assign load_ready_o = (state_q == ST_IDLE) ||
                          ((GAP == 0) && (state_q == ST_SHIFT) && w_last);
    assign bit_valid_o  = (state_q == ST_SHIFT);
    assign word_done_o  = (state_q == ST_SHIFT) && w_last;
    assign busy_o       = (state_q != ST_IDLE);
    assign bit_out_o    = (state_q == ST_SHIFT) ? w_head : IDLE_LEVEL;

    assign w_accept     = load_valid_i && load_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    sreg_d  = data_in_i;
                    cnt_d   = C_CNT_WORD;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d = w_shifted;
                if (!w_last) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end else if (w_accept) begin
                    // Only reachable with GAP == 0: reload and keep shifting.
                    sreg_d  = data_in_i;
                    cnt_d   = C_CNT_WORD;
                    state_d = ST_SHIFT;
                end else if (GAP > 0) begin
                    cnt_d   = C_CNT_GAP;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_last) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sreg_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Self-checking bench for bit_serializer. Two instances share the
//             same stimulus: instance 0 uses the defaults (MSB first, GAP=2),
//             instance 1 is LSB first with GAP=0. A timeline model derives
//             every expected output from the cycle distance to the last
//             accepted word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         lv;
    logic [W-1:0] data;

    logic [1:0]   ready, bvalid, bout, done, busy;

    int           nvec = 0;
    int           nerr = 0;
    bit           cmp_en = 1'b0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(2), .IDLE_LEVEL(1'b0)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .load_valid_i(lv), .data_in_i(data),
        .load_ready_o(ready[0]), .bit_out_o(bout[0]), .bit_valid_o(bvalid[0]),
        .word_done_o(done[0]), .busy_o(busy[0])
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .load_valid_i(lv), .data_in_i(data),
        .load_ready_o(ready[1]), .bit_out_o(bout[1]), .bit_valid_o(bvalid[1]),
        .word_done_o(done[1]), .busy_o(busy[1])
    );

    // ---------------- timeline model ----------------
    // cyc numbers the cycle currently in progress; acc_n[i] is the edge
    // number at which instance i last accepted a word. d = cyc - acc_n[i]:
    // d in 1..W -> data bit d-1, d in W+1..W+GAP -> gap, beyond -> idle.
    int           cyc;
    int           acc_n [2];
    logic [W-1:0] acc_w [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 0);
    endfunction

    function automatic bit m_ready(input int i, input int d);
        return (d > W + gap_of(i)) || ((gap_of(i) == 0) && (d == W));
    endfunction

    // returns {ready, valid, bit, done, busy}
    function automatic logic [4:0] m_out(input int i);
        int   d;
        logic v, b, dn, bs;
        d  = cyc - acc_n[i];
        v  = 1'b0; b = 1'b0; dn = 1'b0; bs = 1'b0;
        if (d >= 1 && d <= W) begin
            v  = 1'b1;
            bs = 1'b1;
            b  = msb_of(i) ? acc_w[i][W-d] : acc_w[i][d-1];
            dn = (d == W);
        end else if (d >= 1 && d <= W + gap_of(i)) begin
            bs = 1'b1;
        end
        return {m_ready(i, d), v, b, dn, bs};
    endfunction

    initial begin
        cyc   = 0;
        acc_n = '{-1000, -1000};
        acc_w = '{8'h00, 8'h00};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    acc_n[i] = -1000;
                end else if (lv && m_ready(i, cyc - acc_n[i])) begin
                    acc_n[i] = cyc;
                    acc_w[i] = data;
                end
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] e;
                e = m_out(i);
                check($sformatf("dut%0d cyc%0d load_ready", i, cyc), {31'd0, ready[i]},  {31'd0, e[4]});
                check($sformatf("dut%0d cyc%0d bit_valid",  i, cyc), {31'd0, bvalid[i]}, {31'd0, e[3]});
                check($sformatf("dut%0d cyc%0d bit_out",    i, cyc), {31'd0, bout[i]},   {31'd0, e[2]});
                check($sformatf("dut%0d cyc%0d word_done",  i, cyc), {31'd0, done[i]},   {31'd0, e[1]});
                check($sformatf("dut%0d cyc%0d busy",       i, cyc), {31'd0, busy[i]},   {31'd0, e[0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called 2 time units after an edge with both instances idle; returns
    // 2 time units after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        lv   = 1'b1;
        data = w;
        @(posedge clk);
        #2;
        lv   = 1'b0;
        data = W'($urandom);
    endtask

    // Samples n consecutive cycles; the first sampled cycle ends up in the
    // most significant position of each vector.
    task automatic capture(input int n, input int idx,
                           output logic [31:0] bits, output logic [31:0] vals,
                           output logic [31:0] dns,  output logic [31:0] rdys);
        bits = '0; vals = '0; dns = '0; rdys = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bits = {bits[30:0], bout[idx]};
            vals = {vals[30:0], bvalid[idx]};
            dns  = {dns[30:0],  done[idx]};
            rdys = {rdys[30:0], ready[idx]};
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] b0, v0, d0, r0, b1, v1, d1, r1;

        reset = 1'b1;
        lv    = 1'b1;
        data  = 8'hFF;
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        lv    = 1'b0;
        @(negedge clk);
        check("reset load_ready", {31'd0, ready[0]},  32'd1);
        check("reset bit_valid",  {31'd0, bvalid[0]}, 32'd0);
        check("reset bit_out",    {31'd0, bout[0]},   32'd0);
        check("reset busy",       {31'd0, busy[0]},   32'd0);
        idle(2);

        // MSB-first word with gap on instance 0
        send(8'b0100_1101);
        capture(10, 0, b0, v0, d0, r0);
        check("msb bits",       {24'd0, b0[9:2]}, 32'h4D);
        check("msb valid",      v0, 32'b11_1111_1100);
        check("msb word_done",  d0, 32'b00_0000_0100);
        check("msb ready low",  r0, 32'd0);
        @(negedge clk);
        check("msb ready back", {31'd0, ready[0]}, 32'd1);
        idle(3);

        // LSB-first on instance 1
        send(8'h01);
        capture(8, 1, b1, v1, d1, r1);
        check("lsb bits",  b1, 32'h80);
        check("lsb valid", v1, 32'hFF);
        idle(4);

        // back-to-back streaming on instance 1 (GAP=0)
        lv   = 1'b1;
        data = 8'hA5;
        @(posedge clk);
        #2;
        data = 8'h3C;
        fork
            capture(16, 1, b1, v1, d1, r1);
            begin
                repeat (8) @(posedge clk);
                #2;
                lv = 1'b0;
            end
        join
        check("stream bits",      b1, 32'hA53C);
        check("stream valid",     v1, 32'hFFFF);
        check("stream word_done", d1, 32'h0101);
        idle(4);

        // reset in the middle of a word
        send(8'hC3);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("midreset valid0", {31'd0, bvalid[0]}, 32'd0);
        check("midreset ready0", {31'd0, ready[0]},  32'd1);
        check("midreset valid1", {31'd0, bvalid[1]}, 32'd0);
        check("midreset ready1", {31'd0, ready[1]},  32'd1);
        @(posedge clk);
        #2;
        send(8'hF0);
        fork
            capture(8, 0, b0, v0, d0, r0);
            capture(8, 1, b1, v1, d1, r1);
        join
        check("after reset bits0",  b0, 32'hF0);
        check("after reset valid0", v0, 32'hFF);
        check("after reset bits1",  b1, 32'h0F);
        idle(4);

        // load_valid with 8'hFF while instance 0 is shifting and in gap
        send(8'h96);
        lv   = 1'b1;
        data = 8'hFF;
        fork
            capture(10, 0, b0, v0, d0, r0);
            begin
                repeat (9) @(posedge clk);
                #2;
                lv = 1'b0;
            end
        join
        check("busy load bits",  {24'd0, b0[9:2]}, 32'h96);
        check("busy load valid", v0, 32'b11_1111_1100);
        @(negedge clk);
        check("busy load no extra word", {31'd0, busy[0]}, 32'd0);
        idle(12);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            lv    = ($urandom_range(0, 3) != 0);
            data  = W'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #2;
        end
        lv    = 1'b0;
        reset = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
